divider_sweep_ctrl: RTL
=======================

Name: divider_sweep_ctrl

Overview:
- Upstream sequencer for the variable clock divider: drives the divider's ResetVal input and steps it from StartVal toward EndVal.
- Holds each value for a programmable number of divided-clock periods.
- Uses the divider's OutClock as feedback (DivClock) to count dwell periods.
- Produces frequency sweeps (one-shot or ping-pong) for tone/timing generation without CPU involvement.

Parameters:
bw_count, 5, width of divide values; must match the divider's bw_count
bw_dwell, 8, width of the dwell count (in DivClock rising edges)

Ports:
Clock  in  1  system clock; the only clock
Reset  in  1  synchronous, active-high reset
Start  in  1  single-cycle request; begins a sweep when idle
Abort  in  1  stops an active sweep
Mode  in  1  0 = one-shot, 1 = ping-pong loop until Abort
StartVal  in  bw_count  first divide value
EndVal  in  bw_count  final divide value
StepVal  in  bw_count  magnitude of each step
DwellCycles  in  bw_dwell  DivClock rising edges to hold each value
DivClock  in  1  divider OutClock fed back; a Clock-domain register output, so no synchroniser is needed
ResetVal  out  bw_count  divide value to the divider
Busy  out  1  high while a sweep is active
Done  out  1  one-cycle pulse when a one-shot sweep completes

Behaviour:
- Reset (synchronous): state IDLE, ResetVal=0, Busy=0, Done=0, edge counter=0, DivClock history register=0.
- States: IDLE, DWELL, STEP.
- IDLE:
  - Start=1 and Abort=0 in cycle n: latch StartVal/EndVal/StepVal/DwellCycles/Mode.
  - Cycle n+1: ResetVal=StartVal, Busy=1, state DWELL.
  - Direction latched: up if EndVal>=StartVal, else down.
- Parameter substitution: StepVal=0 is used as 1; DwellCycles=0 is used as 1.
- Edge detect: prev<=DivClock every cycle; edge = DivClock & ~prev.
- DWELL:
  - Edge counter clears on entry.
  - Increments on each edge.
  - When an edge brings the count to DwellCycles, go to STEP on the next cycle.
- STEP (one cycle):
  - If ResetVal != target:
    - ResetVal <= ResetVal ± step, computed in bw_count+1 bits.
    - Clamp to target on overshoot or wrap; never pass target, never wrap past 0 or max.
    - Return to DWELL.
  - If ResetVal == target and Mode=0: Done=1 for that one cycle, Busy=0 the same cycle, go to IDLE. ResetVal holds.
  - If ResetVal == target and Mode=1: swap target between StartVal and EndVal, invert direction, take the step toward the new target this cycle, return to DWELL.
- StartVal==EndVal:
  - One-shot: one dwell, then Done.
  - Loop: dwells indefinitely at that value until Abort.
- Abort in any non-IDLE state:
  - Next cycle: IDLE, Busy=0, no Done pulse, ResetVal holds its last value.
  - Abort and Start in the same IDLE cycle: Abort wins; nothing starts.
- Start while Busy: ignored. Input changes during a sweep have no effect (values are latched).
- Latency:
  - Start to new ResetVal: 1 cycle.
  - Final dwell edge to next ResetVal: 2 cycles (edge registered, then STEP).
- Done is never asserted in Mode=1.

Decomposition:
- Shared package: state encoding constants (IDLE, DWELL, STEP) and the default widths, so the divider and this block agree on bw_count.
- One natural sub-module: rise_edge_counter (edge detect plus dwell counter with clear and terminal-count flag). It is reusable by other blocks that count divided-clock periods.

Test Plan:
- Reset mid-sweep: assert Reset during DWELL -> next cycle ResetVal=0, Busy=0, Done=0; a subsequent Start works normally.
- One-shot up: StartVal=2, EndVal=8, StepVal=3, DwellCycles=2, Mode=0, DivClock from a real divider -> ResetVal sequence 2,5,8, each held for 2 DivClock rising edges; Done pulses exactly one cycle; Busy falls with Done.
- Clamp down: StartVal=10, EndVal=1, StepVal=4 -> sequence 10,6,2,1; no wrap below 1.
- Ping-pong: StartVal=3, EndVal=5, StepVal=1, Mode=1 -> 3,4,5,4,3,4,... with no Done. Abort during dwell -> Busy=0 next cycle, ResetVal frozen, no Done.
- Zero substitution: StepVal=0, DwellCycles=0, 4->6 -> steps of 1 held for 1 edge each (4,5,6), then Done.
- Handshake corners: Start while Busy ignored (sequence unchanged); Start+Abort in IDLE -> stays IDLE; StartVal==EndVal=7 one-shot -> single dwell, then Done.

Source files
------------

// File: rtl/divider_sweep_ctrl_pkg.sv
// Shared definitions for the divider sweep sequencer: state encoding and the
// default widths that must agree with the variable clock divider.
package divider_sweep_ctrl_pkg;

  localparam int BW_COUNT_DEFAULT = 5;
  localparam int BW_DWELL_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/divider_sweep_ctrl_rise_edge_counter.sv
// Rising-edge detector plus period counter for a Clock-domain divided clock.
// Hit is combinational: high in the cycle whose edge brings the count to Terminal.
module rise_edge_counter #(
  parameter int bw_dwell = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                DivClock,
  input  logic                Clear,
  input  logic [bw_dwell-1:0] Terminal,
  output logic                Hit
);

  logic                prev;
  logic [bw_dwell-1:0] count;
  logic                rise;
  logic [bw_dwell:0]   count_next;

  assign rise       = DivClock & ~prev;
  assign count_next = {1'b0, count} + {{bw_dwell{1'b0}}, 1'b1};
  assign Hit        = rise && !Clear && (count_next == {1'b0, Terminal});

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev  <= 1'b0;
      count <= '0;
    end else begin
      prev <= DivClock;
      if (Clear) begin
        count <= '0;
      end else if (rise) begin
        count <= count_next[bw_dwell-1:0];
      end
    end
  end

endmodule

// File: rtl/divider_sweep_ctrl.sv
// Sweeps the divider's ResetVal from StartVal toward EndVal, holding each value
// for DwellCycles rising edges of the divider output fed back on DivClock.
module divider_sweep_ctrl
  import divider_sweep_ctrl_pkg::*;
#(
  parameter int bw_count = BW_COUNT_DEFAULT,
  parameter int bw_dwell = BW_DWELL_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Abort,
  input  logic                Mode,
  input  logic [bw_count-1:0] StartVal,
  input  logic [bw_count-1:0] EndVal,
  input  logic [bw_count-1:0] StepVal,
  input  logic [bw_dwell-1:0] DwellCycles,
  input  logic                DivClock,
  output logic [bw_count-1:0] ResetVal,
  output logic                Busy,
  output logic                Done,
  output logic [1:0]          DebugState
);

  // Handshake: Start is a one-cycle request accepted only while Busy=0 and
  // Abort=0; Busy rises the next cycle and Start is ignored until it falls.
  sweep_state_t        state;
  logic [bw_count-1:0] start_q;
  logic [bw_count-1:0] end_q;
  logic [bw_count-1:0] step_q;
  logic [bw_count-1:0] target_q;
  logic [bw_dwell-1:0] dwell_q;
  logic                mode_q;
  logic                up_q;
  logic                dwell_hit;
  logic [bw_count-1:0] turn_target;

  rise_edge_counter #(
    .bw_dwell(bw_dwell)
  ) u_edge_counter (
    .Clock   (Clock),
    .Reset   (Reset),
    .DivClock(DivClock),
    .Clear   (state != DWELL),
    .Terminal(dwell_q),
    .Hit     (dwell_hit)
  );

  // One step toward tgt, clamped so the value never passes tgt or wraps.
  function automatic logic [bw_count-1:0] step_toward(
    input logic [bw_count-1:0] cur,
    input logic [bw_count-1:0] tgt,
    input logic [bw_count-1:0] stp,
    input logic                up
  );
    logic [bw_count:0]   wide;
    logic [bw_count-1:0] res;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, stp};
      res  = (wide > {1'b0, tgt}) ? tgt : wide[bw_count-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, stp};
      res  = (wide[bw_count] || (wide[bw_count-1:0] < tgt)) ? tgt : wide[bw_count-1:0];
    end
    return res;
  endfunction

  assign turn_target = (target_q == end_q) ? start_q : end_q;
  assign DebugState  = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      ResetVal <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      step_q   <= '0;
      target_q <= '0;
      dwell_q  <= '0;
      mode_q   <= 1'b0;
      up_q     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Abort) begin
            start_q  <= StartVal;
            end_q    <= EndVal;
            target_q <= EndVal;
            step_q   <= (StepVal == '0) ? {{(bw_count-1){1'b0}}, 1'b1} : StepVal;
            dwell_q  <= (DwellCycles == '0) ? {{(bw_dwell-1){1'b0}}, 1'b1} : DwellCycles;
            mode_q   <= Mode;
            up_q     <= (EndVal >= StartVal);
            ResetVal <= StartVal;
            Busy     <= 1'b1;
            state    <= DWELL;
          end
        end
        DWELL: begin
          if (Abort) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (dwell_hit) begin
            state <= STEP;
          end
        end
        STEP: begin
          if (Abort) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (ResetVal != target_q) begin
            ResetVal <= step_toward(ResetVal, target_q, step_q, up_q);
            state    <= DWELL;
          end else if (!mode_q) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // Ping-pong turn: reverse and take the first step in the same cycle.
            target_q <= turn_target;
            up_q     <= ~up_q;
            ResetVal <= step_toward(ResetVal, turn_target, step_q, ~up_q);
            state    <= DWELL;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
